// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I MEM-stage load/store unit with req/gnt/rvalid data-memory port
// Optional build macro MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW complete at once with a
// misalign pulse instead of being issued to memory.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic        m_read,
    input  logic        m_write,
    input  logic [2:0]  m_funct3,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        bus_err,
    output logic        misalign,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last REQ/WAIT cycle index before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q;
    logic        dm_req_q;
    logic        dm_we_q;
    logic [31:0] dm_addr_q;
    logic [3:0]  dm_be_q;
    logic [31:0] dm_wdata_q;
    logic [31:0] ld_data_q;
    logic        bus_err_q;
    logic        misalign_q;
    logic [7:0]  cnt_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;

    logic        mem_op;
    logic        cnt_hit;
    logic        mis_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;

    assign mem_op  = m_valid & (m_read | m_write);
    assign stall   = mem_op & (state_q != S_DONE);
    assign cnt_hit = (cnt_q == CNT_LAST);

    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_be    = dm_be_q;
    assign dm_wdata = dm_wdata_q;
    assign ld_data  = ld_data_q;
    assign bus_err  = bus_err_q;
    assign misalign = misalign_q;

    // Misalignment detection for the incoming access (only meaningful when trapping).
    always_comb begin
        mis_c = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (m_funct3[1:0] == 2'b01 && m_addr[0])
            mis_c = 1'b1;
        else if (m_funct3 == 3'b010 && m_addr[1:0] != 2'b00)
            mis_c = 1'b1;
`endif
    end

    // Store byte enables and lane-replicated store data; loads drive no enables.
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = 32'h0;
        if (m_write) begin
            case (m_funct3[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << m_addr[1:0];
                    wdata_c = {4{m_wdata[7:0]}};
                end
                2'b01: begin
                    // A halfword at byte 3 only keeps the byte that still fits in the word.
                    be_c    = (m_addr[1:0] == 2'b11) ? 4'b1000 : (4'b0011 << {m_addr[1], 1'b0});
                    wdata_c = {2{m_wdata[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = m_wdata;
                end
            endcase
        end
    end

    // Lane selection and sign/zero extension of the returned word.
    always_comb begin
        case (addr_lo_q)
            2'b00:   rd_byte = dm_rdata[7:0];
            2'b01:   rd_byte = dm_rdata[15:8];
            2'b10:   rd_byte = dm_rdata[23:16];
            default: rd_byte = dm_rdata[31:24];
        endcase
        rd_half = addr_lo_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {24'h0, rd_byte};
            3'b101:  ld_ext = {16'h0, rd_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    // Access sequencer: accept, request, wait for data, report completion for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 32'h0;
            dm_be_q    <= 4'b0000;
            dm_wdata_q <= 32'h0;
            ld_data_q  <= 32'h0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= 8'd0;
            funct3_q   <= 3'b000;
            addr_lo_q  <= 2'b00;
        end else begin
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        dm_we_q    <= m_write;
                        funct3_q   <= m_funct3;
                        addr_lo_q  <= m_addr[1:0];
                        dm_addr_q  <= {m_addr[31:2], 2'b00};
                        dm_be_q    <= be_c;
                        dm_wdata_q <= wdata_c;
                        cnt_q      <= 8'd0;
                        if (mis_c) begin
                            state_q    <= S_DONE;
                            misalign_q <= 1'b1;
                            ld_data_q  <= 32'h0;
                        end else begin
                            state_q  <= S_REQ;
                            dm_req_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (dm_gnt && dm_we_q) begin
                        dm_req_q <= 1'b0;
                        state_q  <= S_DONE;
                    end else if (cnt_hit) begin
                        // A load granted in its last allowed cycle can no longer finish in time.
                        dm_req_q  <= 1'b0;
                        state_q   <= S_DONE;
                        bus_err_q <= 1'b1;
                        ld_data_q <= 32'h0;
                    end else if (dm_gnt) begin
                        dm_req_q <= 1'b0;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (dm_rvalid) begin
                        ld_data_q <= ld_ext;
                        state_q   <= S_DONE;
                    end else if (cnt_hit) begin
                        state_q   <= S_DONE;
                        bus_err_q <= 1'b1;
                        ld_data_q <= 32'h0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        m_valid;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_funct3;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        bus_err;
    logic        misalign;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    int total;
    int bad;
    logic [31:0] mdl_ld;

    mem_stage_lsu #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_read(m_read), .m_write(m_write),
        .m_funct3(m_funct3), .m_addr(m_addr), .m_wdata(m_wdata),
        .stall(stall), .ld_data(ld_data), .bus_err(bus_err), .misalign(misalign),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: store byte enables and data, computed lane by lane with arithmetic.
    function automatic logic [31:0] ref_be(input bit is_ld, input logic [2:0] f3, input int a);
        if (is_ld) return 0;
        if (f3[1:0] == 2'b00) return 32'(1 << a);
        if (f3[1:0] == 2'b01) return (a == 3) ? 32'd8 : 32'(3 << (a & 2));
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wd(input bit is_ld, input logic [2:0] f3, input logic [31:0] w);
        if (is_ld) return 0;
        if (f3[1:0] == 2'b00) return (w & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'b01) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] ref_ld(input logic [2:0] f3, input int a, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit ref_mis(input logic [2:0] f3, input int a);
`ifdef MISALIGN_TRAP_EN
        if (f3[1:0] == 2'b01 && (a % 2) == 1) return 1'b1;
        if (f3 == 3'd2 && a != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // One complete access; the bench plays the memory with gd wait cycles before gnt
    // and rdd WAIT cycles before rvalid, then checks latency, request fields and result.
    task automatic run_op(input bit is_ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat,
                          input int gd, input int rdd, input bit scramble);
        int n_stall, n_req, n_wait, need, exp_stall, exp_req;
        bit granted, fin, seen, mis, tmo, gnt_n, rv_n;
        logic [31:0] exp_ld;
        int lo;
        lo = int'(a[1:0]);
        mis = ref_mis(f3, lo);
        need = is_ld ? gd + rdd + 2 : gd + 1;
        tmo = !mis && (need > TO);
        exp_stall = mis ? 1 : (tmo ? TO + 1 : need + 1);
        exp_req = mis ? 0 : ((gd + 1 < TO) ? gd + 1 : TO);
        if (mis || tmo) exp_ld = 0;
        else if (is_ld) exp_ld = ref_ld(f3, lo, rdat);
        else exp_ld = mdl_ld;

        @(negedge clk);
        m_valid = 1'b1; m_read = is_ld; m_write = !is_ld;
        m_funct3 = f3; m_addr = a; m_wdata = wd;
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        n_stall = 0; n_req = 0; n_wait = 0; granted = 0; fin = 0; seen = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            #1;
            gnt_n = 1'b0; rv_n = 1'b0; dm_rdata = $urandom;
            if (!stall) begin
                fin = 1;
                rv_n = ($urandom_range(0, 1) == 0);
                check("stall_cycles", n_stall, exp_stall);
                check("req_cycles", n_req, exp_req);
                check("bus_err", {31'h0, bus_err}, {31'h0, tmo});
                check("misalign", {31'h0, misalign}, {31'h0, mis});
                check("ld_data", ld_data, exp_ld);
            end else begin
                n_stall++;
                if (dm_req) begin
                    if (!seen) begin
                        seen = 1;
                        check("dm_addr", dm_addr, {a[31:2], 2'b00});
                        check("dm_we", {31'h0, dm_we}, {31'h0, !is_ld});
                        check("dm_be", {28'h0, dm_be}, ref_be(is_ld, f3, lo));
                        check("dm_wdata", dm_wdata, ref_wd(is_ld, f3, wd));
                    end
                    gnt_n = (n_req == gd);
                    rv_n = ($urandom_range(0, 3) == 0);
                    n_req++;
                end else if (granted) begin
                    if (n_wait == rdd) begin
                        rv_n = 1'b1;
                        dm_rdata = rdat;
                    end
                    n_wait++;
                end else begin
                    rv_n = ($urandom_range(0, 3) == 0);
                end
                if (gnt_n) granted = 1;
            end
            dm_gnt = gnt_n;
            dm_rvalid = rv_n;
            if (!fin) begin
                @(negedge clk);
                if (scramble) begin
                    m_funct3 = 3'($urandom); m_addr = $urandom; m_wdata = $urandom;
                end
            end
        end
        if (!fin) check("op_finished", 0, 1);
        mdl_ld = exp_ld;
    endtask

    // A cycle with no memory instruction: nothing may stall or request.
    task automatic idle_cycle();
        @(negedge clk);
        m_valid = 1'($urandom); m_read = 1'b0; m_write = 1'b0;
        if ($urandom_range(0, 1) == 0) begin
            m_valid = 1'b0; m_read = 1'($urandom); m_write = !m_read;
        end
        dm_gnt = 1'b0; dm_rvalid = 1'($urandom); dm_rdata = $urandom;
        #1;
        check("idle_stall", {31'h0, stall}, 0);
        check("idle_req", {31'h0, dm_req}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; mdl_ld = 0;
        rst = 1'b0; m_valid = 1'b0; m_read = 1'b0; m_write = 1'b0;
        m_funct3 = 3'd0; m_addr = 32'h0; m_wdata = 32'h0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", {31'h0, dm_req}, 0);
        check("rst_we", {31'h0, dm_we}, 0);
        check("rst_addr", dm_addr, 0);
        check("rst_be", {28'h0, dm_be}, 0);
        check("rst_wdata", dm_wdata, 0);
        check("rst_ld", ld_data, 0);
        check("rst_err", {30'h0, bus_err, misalign}, 0);
        check("rst_stall", {31'h0, stall}, 0);
        @(negedge clk); rst = 1'b1;

        // Reset while a request is outstanding drops dm_req immediately.
        @(negedge clk);
        m_valid = 1'b1; m_read = 1'b1; m_write = 1'b0; m_funct3 = 3'd2; m_addr = 32'h40;
        @(negedge clk); #1;
        check("req_before_rst", {31'h0, dm_req}, 1);
        rst = 1'b0; #1;
        check("req_async_drop", {31'h0, dm_req}, 0);
        m_valid = 1'b0;
        @(negedge clk); rst = 1'b1;

        // Reset mid-WAIT, then a late rvalid must not be captured.
        @(negedge clk);
        m_valid = 1'b1; m_read = 1'b1; m_write = 1'b0; m_funct3 = 3'd2; m_addr = 32'h80;
        @(negedge clk); dm_gnt = 1'b1;
        @(negedge clk); dm_gnt = 1'b0; #1;
        check("wait_stall", {31'h0, stall}, 1);
        rst = 1'b0; #1;
        check("wait_rst_req", {31'h0, dm_req}, 0);
        m_valid = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h80FF0000;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("late_rvalid_ld", ld_data, 0);
        check("late_rvalid_req", {31'h0, dm_req}, 0);
        check("late_rvalid_stall", {31'h0, stall}, 0);
        dm_rvalid = 1'b0;

        // Directed cases.
        run_op(1, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0);
        run_op(0, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 3, 0, 1);
        run_op(1, 3'd2, 32'h100, 32'h0, 32'h0, 20, 0, 0);
        run_op(1, 3'd2, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0, 0);
        run_op(1, 3'd4, 32'h1, 32'h0, 32'h00009900, 0, 0, 0);
        run_op(0, 3'd2, 32'h304, 32'hA5A55A5A, 32'h0, 0, 0, 0);
        run_op(0, 3'd1, 32'h203, 32'h0000BEEF, 32'h0, 1, 0, 0);
        run_op(1, 3'd2, 32'h400, 32'h0, 32'h11223344, 3, 3, 0);
        run_op(1, 3'd2, 32'h400, 32'h0, 32'h55667788, 4, 3, 0);
        idle_cycle();

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            bit ld;
            logic [2:0] f3;
            int gd;
            ld = 1'($urandom);
            f3 = ld ? 3'($urandom) : 3'($urandom_range(0, 2));
            gd = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 12) : $urandom_range(0, 3);
            run_op(ld, f3, $urandom, $urandom, $urandom, gd, $urandom_range(0, 3),
                   1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
